tick_scheduler: RTL

TICK_SCHEDULER -- requirements
Module: tick_scheduler

---
 rtl/tick_scheduler.sv | 106 ++++++++++
 1 files changed

// File: rtl/tick_scheduler.sv
// Multi-channel periodic tick generator. A one-deep config port (IDLE/APPLY)
// loads each channel's period/enable; a global sync strobe realigns all phases.
module tick_scheduler #(
  parameter int NCH   = 4,
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [$clog2(NCH)-1:0]  cfg_ch,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic                    cfg_en,
  input  logic                    sync,
  output logic [NCH-1:0]          tick,
  output logic [NCH-1:0]          active,
  output logic                    cfg_err
);

  localparam int CH_W = $clog2(NCH);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_APPLY = 1'b1;

  logic [0:0]       r_state;
  logic [CH_W-1:0]  r_cfg_ch;
  logic [CNT_W-1:0] r_cfg_period;
  logic             r_cfg_en;
  logic             r_err;

  logic w_xfer;
  logic w_apply;
  logic w_reject;

  assign cfg_ready = (r_state == S_IDLE);
  assign w_xfer    = cfg_valid && cfg_ready;
  assign w_apply   = (r_state == S_APPLY);
  // Enabling a channel with a zero period would never tick; refuse it.
  assign w_reject  = r_cfg_en && (r_cfg_period == '0);
  assign cfg_err   = r_err;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cfg_ch     <= '0;
      r_cfg_period <= '0;
      r_cfg_en     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err <= w_apply && w_reject;
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_cfg_ch     <= cfg_ch;
            r_cfg_period <= cfg_period;
            r_cfg_en     <= cfg_en;
            r_state      <= S_APPLY;
          end
        end
        S_APPLY: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [CNT_W-1:0] r_per;
    logic [CNT_W-1:0] r_cnt;
    logic             r_en;
    logic             r_tick;
    logic             w_tgt;

    assign w_tgt     = w_apply && (r_cfg_ch == CH_W'(g));
    assign tick[g]   = r_tick;
    assign active[g] = r_en;

    // NOTE: the period registers are reset too, because a freshly reset
    // channel must read back P = 0 rather than whatever powered up.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_per  <= '0;
        r_cnt  <= '0;
        r_en   <= 1'b0;
        r_tick <= 1'b0;
      end else if (w_tgt) begin
        // Restart from phase zero; the old period must not leak a tick.
        r_cnt  <= '0;
        r_tick <= 1'b0;
        r_en   <= r_cfg_en && !w_reject;
        if (!w_reject) r_per <= r_cfg_period;
      end else if (sync || !r_en) begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
      end else if (r_cnt == r_per - CNT_W'(1)) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_tick <= 1'b0;
      end
    end
  end

endmodule
